// File: rtl/dram_refresh_resp.sv
// CAS-before-RAS refresh responder: one refresh per RefReq window, opportunistic when idle, forced via RAMHold when urgent.
// All outputs registered; strobes follow the edge that enters each phase; misses counted with saturation.
module dram_refresh_resp #(
    parameter int T_CR  = 1,
    parameter int T_RAS = 3,
    parameter int T_PRE = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RefReq,
    input  logic       RefUrg,
    input  logic       BACT,
    input  logic       RAMReq,
    output logic       nRefRAS,
    output logic       nRefCAS,
    output logic       RefAct,
    output logic       RAMHold,
    output logic       RefDone,
    output logic       RefMiss,
    output logic [3:0] MissCnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_URGWAIT,
        S_CAS,
        S_RAS,
        S_PRE
    } state_t;

    localparam logic [2:0] LP_CR_LAST  = 3'(T_CR - 1);
    localparam logic [2:0] LP_RAS_LAST = 3'(T_RAS - 1);
    localparam logic [2:0] LP_PRE_LAST = 3'(T_PRE - 1);

    state_t     r_state;
    state_t     w_nxt_state;
    logic [2:0] r_phase;
    logic [2:0] w_nxt_phase;
    logic       r_ref_req_d;
    logic       r_ras_n;
    logic       r_cas_n;
    logic       r_act;
    logic       r_hold;
    logic       r_done;
    logic       r_miss;
    logic [3:0] r_miss_cnt;
    logic       w_pending;
    logic       w_idle_like;
    logic       w_seq_end;
    logic       w_miss;
    logic       w_nxt_seq;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_pending   = RefReq && !r_done;
        w_idle_like = (r_state == S_IDLE) || (r_state == S_URGWAIT);
        case (r_state)
            S_IDLE: begin
                // Non-urgent refresh yields to a RAM request on the same clock.
                if (w_pending && !BACT && (RefUrg || !RAMReq)) begin
                    w_nxt_state = S_CAS;
                end else if (w_pending && RefUrg && BACT) begin
                    w_nxt_state = S_URGWAIT;
                end
            end
            S_URGWAIT: begin
                if (!BACT) begin
                    w_nxt_state = S_CAS;
                end
            end
            S_CAS: begin
                w_nxt_phase = r_phase + 3'd1;
                if (r_phase == LP_CR_LAST) begin
                    w_nxt_state = S_RAS;
                end
            end
            S_RAS: begin
                w_nxt_phase = r_phase + 3'd1;
                if (r_phase == LP_RAS_LAST) begin
                    w_nxt_state = S_PRE;
                end
            end
            S_PRE: begin
                w_nxt_phase = r_phase + 3'd1;
                if (r_phase == LP_PRE_LAST) begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
        if (w_nxt_state != r_state) begin
            w_nxt_phase = 3'd0;
        end
        w_seq_end = (r_state == S_PRE) && (w_nxt_state == S_IDLE);
        w_miss    = r_ref_req_d && !RefReq && !r_done && w_idle_like;
        w_nxt_seq = (w_nxt_state == S_CAS) || (w_nxt_state == S_RAS) || (w_nxt_state == S_PRE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_phase     <= 3'd0;
            r_ref_req_d <= 1'b0;
            r_ras_n     <= 1'b1;
            r_cas_n     <= 1'b1;
            r_act       <= 1'b0;
            r_hold      <= 1'b0;
            r_done      <= 1'b0;
            r_miss      <= 1'b0;
            r_miss_cnt  <= 4'd0;
        end else begin
            r_state     <= w_nxt_state;
            r_phase     <= w_nxt_phase;
            r_ref_req_d <= RefReq;
            // Strobes are decoded from the next state so they change on the entering edge.
            r_cas_n     <= !((w_nxt_state == S_CAS) || (w_nxt_state == S_RAS));
            r_ras_n     <= !(w_nxt_state == S_RAS);
            r_act       <= w_nxt_seq;
            r_hold      <= w_nxt_seq || (w_nxt_state == S_URGWAIT);
            if (w_seq_end) begin
                r_done <= RefReq;
            end else if (w_idle_like && !RefReq) begin
                r_done <= 1'b0;
            end
            r_miss <= w_miss;
            if (w_miss && (r_miss_cnt != 4'hF)) begin
                r_miss_cnt <= r_miss_cnt + 4'd1;
            end
        end
    end

    assign nRefRAS = r_ras_n;
    assign nRefCAS = r_cas_n;
    assign RefAct  = r_act;
    assign RAMHold = r_hold;
    assign RefDone = r_done;
    assign RefMiss = r_miss;
    assign MissCnt = r_miss_cnt;

endmodule

// File: tb/tb_dram_refresh_resp.sv
// Bench for dram_refresh_resp: two parameterisations share stimulus and are checked every cycle
// against a time-offset reference model (sequence start edge + arithmetic on elapsed cycles).
module tb_dram_refresh_resp;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RefReq, RefUrg, BACT, RAMReq;
    logic       nRefRAS0, nRefCAS0, RefAct0, RAMHold0, RefDone0, RefMiss0;
    logic [3:0] MissCnt0;
    logic       nRefRAS1, nRefCAS1, RefAct1, RAMHold1, RefDone1, RefMiss1;
    logic [3:0] MissCnt1;

    always #5 CLK = ~CLK;

    dram_refresh_resp #(.T_CR(1), .T_RAS(3), .T_PRE(2)) u_dut0 (
        .CLK(CLK), .RST(RST), .RefReq(RefReq), .RefUrg(RefUrg), .BACT(BACT), .RAMReq(RAMReq),
        .nRefRAS(nRefRAS0), .nRefCAS(nRefCAS0), .RefAct(RefAct0), .RAMHold(RAMHold0),
        .RefDone(RefDone0), .RefMiss(RefMiss0), .MissCnt(MissCnt0)
    );

    dram_refresh_resp #(.T_CR(2), .T_RAS(4), .T_PRE(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .RefReq(RefReq), .RefUrg(RefUrg), .BACT(BACT), .RAMReq(RAMReq),
        .nRefRAS(nRefRAS1), .nRefCAS(nRefCAS1), .RefAct(RefAct1), .RAMHold(RAMHold1),
        .RefDone(RefDone1), .RefMiss(RefMiss1), .MissCnt(MissCnt1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a refresh is "in flight" from its start edge for L cycles.
    int TCR[2]  = '{1, 2};
    int TRAS[2] = '{3, 4};
    int L[2]    = '{6, 7};
    int n;
    bit m_seq[2], m_wait[2], m_done[2], m_reqd[2], m_miss[2];
    int m_start[2], m_cnt[2];

    int cas_low[2], ras_low[2], act_hi[2], cas_falls[2], first_cas[2], first_done[2];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, act, exp, n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_seq[i] = 0; m_wait[i] = 0; m_done[i] = 0; m_reqd[i] = 0;
            m_miss[i] = 0; m_cnt[i] = 0; m_start[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        bit pend, miss;
        miss = 0;
        if (m_seq[i]) begin
            if (n - m_start[i] == L[i]) begin
                m_seq[i]  = 0;
                m_done[i] = RefReq;
            end
        end else begin
            pend = RefReq && !m_done[i];
            miss = m_reqd[i] && !RefReq && !m_done[i];
            if (!RefReq) m_done[i] = 0;
            if (m_wait[i]) begin
                if (!BACT) begin
                    m_wait[i] = 0; m_seq[i] = 1; m_start[i] = n;
                end
            end else if (pend && !BACT && (RefUrg || !RAMReq)) begin
                m_seq[i] = 1; m_start[i] = n;
            end else if (pend && RefUrg && BACT) begin
                m_wait[i] = 1;
            end
        end
        m_miss[i] = miss;
        if (miss && m_cnt[i] < 15) m_cnt[i]++;
        m_reqd[i] = RefReq;
    endtask

    function automatic logic [9:0] exp_vec(input int i);
        int j;
        logic casl, rasl;
        j    = n - m_start[i];
        casl = m_seq[i] && (j < TCR[i] + TRAS[i]);
        rasl = m_seq[i] && (j >= TCR[i]) && (j < TCR[i] + TRAS[i]);
        return {!rasl, !casl, m_seq[i], m_seq[i] | m_wait[i], m_done[i], m_miss[i], 4'(m_cnt[i])};
    endfunction

    function automatic logic [9:0] act_vec(input int i);
        if (i == 0) return {nRefRAS0, nRefCAS0, RefAct0, RAMHold0, RefDone0, RefMiss0, MissCnt0};
        return {nRefRAS1, nRefCAS1, RefAct1, RAMHold1, RefDone1, RefMiss1, MissCnt1};
    endfunction

    task automatic check_all();
        logic [9:0] a0, a1;
        a0 = act_vec(0);
        a1 = act_vec(1);
        check_val("outs_p0", a0, exp_vec(0));
        check_val("outs_p1", a1, exp_vec(1));
        check_val("cbr_p0", !a0[9] && a0[8], 0);
        check_val("cbr_p1", !a1[9] && a1[8], 0);
    endtask

    task automatic cycle();
        @(posedge CLK);
        n++;
        if (RST) model_reset();
        else begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge CLK);
        check_all();
    endtask

    task automatic run(input int k);
        repeat (k) cycle();
    endtask

    task automatic run_stats(input int k);
        logic [9:0] v;
        logic prev_cas[2];
        for (int i = 0; i < 2; i++) begin
            cas_low[i] = 0; ras_low[i] = 0; act_hi[i] = 0; cas_falls[i] = 0;
            first_cas[i] = -1; first_done[i] = -1; prev_cas[i] = act_vec(i)[8];
        end
        for (int c = 0; c < k; c++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                v = act_vec(i);
                if (!v[8]) cas_low[i]++;
                if (!v[9]) ras_low[i]++;
                if (v[7]) act_hi[i]++;
                if (prev_cas[i] && !v[8]) cas_falls[i]++;
                if (!v[8] && first_cas[i] < 0) first_cas[i] = c;
                if (v[5] && first_done[i] < 0) first_done[i] = c;
                prev_cas[i] = v[8];
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        RST = 1'b0;
    endtask

    initial begin
        bit found;
        int hi;
        RST = 1'b1; RefReq = 0; RefUrg = 0; BACT = 0; RAMReq = 0;
        n = 0;
        model_reset();
        @(negedge CLK);
        check_all();
        cycle();
        RST = 1'b0;
        run(2);

        // Opportunistic refresh, then no repeat while the window stays open.
        RefReq = 1;
        run_stats(25);
        check_val("opp_cas_len_p0", cas_low[0], 4);
        check_val("opp_ras_len_p0", ras_low[0], 3);
        check_val("opp_act_len_p0", act_hi[0], 6);
        check_val("opp_done_edge_p0", first_done[0] - first_cas[0], 6);
        check_val("opp_one_ref_p0", cas_falls[0], 1);
        check_val("sweep_cas_len_p1", cas_low[1], 6);
        check_val("sweep_ras_len_p1", ras_low[1], 4);
        check_val("sweep_done_edge_p1", first_done[1] - first_cas[1], 7);

        // Window roll re-arms without a miss.
        RefReq = 0;
        cycle();
        RefReq = 1;
        run_stats(20);
        check_val("roll_one_ref_p0", cas_falls[0], 1);
        check_val("roll_one_ref_p1", cas_falls[1], 1);
        check_val("roll_nomiss_p0", MissCnt0, 0);

        // Contention: RAMReq blocks a non-urgent refresh; urgency forces it.
        RefReq = 0; RAMReq = 1;
        cycle();
        RefReq = 1;
        run(8);
        check_val("cont_noref_p0", RefAct0, 0);
        RefUrg = 1; BACT = 1;
        cycle();
        check_val("urg_hold_p0", RAMHold0, 1);
        check_val("urg_noact_p0", RefAct0, 0);
        run(3);
        BACT = 0;
        cycle();
        check_val("urg_cas_p0", {RefAct0, nRefCAS0}, 2'b10);
        RefUrg = 0; RAMReq = 0;
        run(10);

        // Missed windows while the bus stays busy; counter saturates.
        BACT = 1; RefReq = 0;
        cycle();
        for (int w = 0; w < 17; w++) begin
            RefReq = 1;
            for (int c = 0; c < 10; c++) begin
                RefUrg = (c >= 7);
                cycle();
                if (w == 1 && c == 0) check_val("miss_pulse_end_p0", RefMiss0, 0);
            end
            RefReq = 0; RefUrg = 0;
            cycle();
            if (w == 0) begin
                check_val("miss_pulse_p0", RefMiss0, 1);
                check_val("miss_cnt1_p0", MissCnt0, 1);
            end
        end
        check_val("miss_sat_p0", MissCnt0, 15);
        check_val("miss_sat_p1", MissCnt1, 15);
        BACT = 0;
        run(12);

        // Reset in the middle of the RAS phase.
        RefReq = 1;
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            cycle();
            if (m_seq[0] && (n - m_start[0] == 2)) found = 1;
        end
        check_val("midseq_reach", found, 1);
        check_val("midseq_ras_low_p0", nRefRAS0, 0);
        do_reset();
        check_val("rst_strobes_p0", {nRefRAS0, nRefCAS0, RefAct0, RAMHold0}, 4'b1100);
        run_stats(15);
        check_val("post_rst_ref_p0", cas_falls[0], 1);
        check_val("post_rst_ref_p1", cas_falls[1], 1);

        // Randomized windows with bus traffic and occasional resets.
        for (int w = 0; w < 150; w++) begin
            hi = $urandom_range(4, 25);
            for (int c = 0; c < hi; c++) begin
                RefReq = 1;
                RefUrg = (c >= hi - 3);
                BACT   = ($urandom_range(0, 3) == 0);
                RAMReq = ($urandom_range(0, 2) == 0);
                cycle();
            end
            repeat ($urandom_range(1, 2)) begin
                RefReq = 0; RefUrg = 0;
                BACT   = ($urandom_range(0, 3) == 0);
                RAMReq = ($urandom_range(0, 2) == 0);
                cycle();
            end
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
